// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state encoding and select constants for the 2:1 arbiter.
package mux2_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_dp.sv
// mux2_dp: W-bit 2:1 mux, s=0 passes a, s=1 passes b.
module mux2_dp #(
  parameter int W = 9
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter feeding a registered 2:1 mux output stage.
// Define MUX2_ARB_HOLD_EN to lock the channel to a requester until its last beat.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic              a_last,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_last,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              y_valid,
  output logic              y_last,
  output logic [DATA_W-1:0] y_data,
  input  logic              y_ready,
  output logic              sel,
  output logic              busy
);
  state_t            state, state_nxt;
  logic              prio, win, has_win, can_load, va, vb, acc, m_last;
  logic [DATA_W-1:0] m_data;
  always_comb begin
    can_load = !y_valid || y_ready;
    va       = a_valid && state != LOCK_B;
    vb       = b_valid && state != LOCK_A;
    has_win  = va || vb;
    win      = (va && vb) ? ~prio : vb;
    acc      = can_load && has_win;
    a_ready  = rst_n && acc && win == SEL_A;
    b_ready  = rst_n && acc && win == SEL_B;
  end
  mux2_dp #(.W(DATA_W + 1)) u_dp (
    .s(win),
    .a({a_last, a_data}),
    .b({b_last, b_data}),
    .y({m_last, m_data})
  );
`ifdef MUX2_ARB_HOLD_EN
  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = m_last ? IDLE : (win == SEL_A ? LOCK_A : LOCK_B);
  end
`else
  assign state_nxt = IDLE;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= SEL_B;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_data  <= '0;
      sel     <= SEL_A;
    end else begin
      state <= state_nxt;
      if (can_load) begin
        y_valid <= has_win;
        if (has_win) begin
          y_data <= m_data;
          y_last <= m_last;
          sel    <= win;
          prio   <= win;
        end
      end
    end
  end
  assign busy = state != IDLE || y_valid;
endmodule
